multiword_adder_seq: RTL and testbench
======================================

Name: multiword_adder_seq

Overview:
Sequential multi-word adder. It adds two WORDS*SIZE-bit operands over WORDS clock cycles, one SIZE-bit slice per cycle. Each slice goes through one instance of the existing gate-level ripple adder (adder_generate_gates), and the carry is registered between slices. It sits directly around that combinational adder: it feeds the adder's A/B/cin and consumes its Sum/cout. This gives wide additions without a long combinational carry chain.

Parameters:
SIZE, 4, bit width of one slice; equals the SIZE of the internal adder instance
WORDS, 4, number of slices per operation; total operand width is SIZE*WORDS; must be >= 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request a new operation; sampled on rising clk
op_a  input  SIZE*WORDS  operand A; sampled when start is accepted
op_b  input  SIZE*WORDS  operand B; sampled when start is accepted
cin  input  1  carry-in to slice 0; sampled when start is accepted
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when result and cout are updated
result  output  SIZE*WORDS  sum of the last completed operation
cout  output  1  carry-out of the last completed operation

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0: state=IDLE, busy=0, done=0, result=0, cout=0, and all internal registers (operand copies, carry, slice index, working sum) are 0.
- States: IDLE, RUN, DONE.
- IDLE: if start=1, latch op_a, op_b, cin into the carry register, set idx=0, go to RUN, set busy=1.
- RUN, each cycle:
  - adder inputs: A=a_reg[idx*SIZE +: SIZE], B=b_reg[idx*SIZE +: SIZE], cin=carry_reg.
  - on the edge: work[idx*SIZE +: SIZE] <= Sum, carry_reg <= adder cout, idx <= idx+1.
- RUN exit: the edge that processes idx=WORDS-1 copies the completed work (including this final slice) into result, copies the final carry into cout, and goes to DONE. busy=0 and done=1 during the DONE cycle.
- DONE: lasts exactly one cycle. With start=0 it goes to IDLE and done drops. With start=1 it accepts the new operation exactly as IDLE does (back-to-back), and done is still 1 in that cycle.
- Latency: start sampled at edge k; RUN covers edges k+1..k+WORDS; done is high from edge k+WORDS to edge k+WORDS+1. Throughput is one operation per WORDS+1 cycles.
- Start while busy (RUN): ignored; op_a/op_b/cin changes have no effect; no queuing.
- result and cout hold their value from the previous completion until the next done. They never show partial sums.
- Arithmetic: {cout,result} = op_a + op_b + cin, modulo 2^(SIZE*WORDS+1). Wrap-around gives result=0, cout=1 for all-ones + 1.
- idx width: clog2(WORDS), minimum 1 bit. idx never exceeds WORDS-1.
- Reset mid-operation: immediate return to the reset state. No done pulse. The aborted operation is discarded; the next start begins a fresh operation.
- WORDS=1: behaves as a registered single adder; done is one cycle after start.

Decomposition:
- Shared include/package: state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and a clog2 function for idx width.
- Sub-module: the existing adder_generate_gates, one instance with SIZE passed through. No other sub-modules; the FSM, datapath registers and slice mux/demux live in multiword_adder_seq.

Test Plan:
- Reset: rst_n=0 for 3 cycles, then release with start=0 -> busy=0, done=0, result=0x0000, cout=0, held stable.
- Basic add (SIZE=4, WORDS=4): op_a=0x1234, op_b=0x4321, cin=1, start pulse -> busy high for 4 cycles; done on the 4th edge after start; result=0x5556, cout=0.
- Full carry ripple across slices: op_a=0xFFFF, op_b=0x0001, cin=0 -> result=0x0000, cout=1. Also op_a=0xFFFF, op_b=0xFFFF, cin=1 -> result=0xFFFF, cout=1.
- Start while busy / back-to-back:
  - during RUN, pulse start with op_a=0xAAAA -> ignored; first result is unchanged.
  - assert start in the DONE cycle with 0x0F0F+0x00F1 -> accepted; second done 5 cycles after the first; result=0x1000.
- Reset mid-operation: start 0x1234+0x4321, drop rst_n after 2 RUN cycles -> outputs zero immediately, no done. A new start of 0x0001+0x0001 gives result=0x0002.
- Exhaustive WORDS=1, SIZE=4: all 512 combinations of A, B, cin -> {cout,result}==A+B+cin, done exactly 1 cycle after each start.

Source files
------------

// File: rtl/multiword_adder_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multiword_adder_seq_pkg
//  Purpose  : Shared definitions for the sequential multi-word adder:
//             FSM state encoding and the slice-index width helper.
//  Contents : state_t   - ST_IDLE / ST_RUN / ST_DONE
//             idx_width - ceil(log2(n)), never less than 1
//  Revision : 1.0 - initial release
// ============================================================================
package multiword_adder_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Width needed to count 0..n-1. A single slice still gets a 1-bit index
   // so the index register never collapses to zero width.
   function automatic int idx_width(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) begin
            w = i + 1;
         end
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage : multiword_adder_seq_pkg
`default_nettype wire

// File: rtl/adder_generate_gates.sv
`default_nettype none
// ============================================================================
//  Module   : adder_generate_gates
//  Purpose  : Gate-level ripple-carry adder, one full adder per bit built
//             from xor/and/or primitives.
//  Ports    : A, B  [SIZE-1:0] in  - addends
//             cin   1          in  - carry into bit 0
//             Sum   [SIZE-1:0] out - A + B + cin (low SIZE bits)
//             cout  1          out - carry out of the top bit
//  Revision : 1.0 - initial release
// ============================================================================
module adder_generate_gates #(
   parameter int SIZE = 4
) (
   input  logic [SIZE-1:0] A,
   input  logic [SIZE-1:0] B,
   input  logic            cin,
   output logic [SIZE-1:0] Sum,
   output logic            cout
);

   wire [SIZE:0] c;

   assign c[0] = cin;

   genvar i;
   generate
      for (i = 0; i < SIZE; i++) begin : g_bit
         wire p;
         wire g_ab;
         wire g_pc;
         xor u_xor_p   (p,        A[i], B[i]);
         xor u_xor_s   (Sum[i],   p,    c[i]);
         and u_and_ab  (g_ab,     A[i], B[i]);
         and u_and_pc  (g_pc,     p,    c[i]);
         or  u_or_c    (c[i+1],   g_ab, g_pc);
      end
   endgenerate

   assign cout = c[SIZE];

endmodule : adder_generate_gates
`default_nettype wire

// File: rtl/multiword_adder_seq.sv
`default_nettype none
// ============================================================================
//  Module   : multiword_adder_seq
//  Purpose  : Adds two SIZE*WORDS-bit operands one SIZE-bit slice per clock
//             through a single ripple adder, registering the carry between
//             slices. Keeps the combinational carry chain at SIZE bits.
//  Ports    : clk, rst_n        in  - clock (rising), async active-low reset
//             start             in  - request; taken in IDLE or DONE
//             op_a, op_b        in  - operands, captured on accept
//             cin               in  - carry into slice 0, captured on accept
//             busy              out - operation in progress
//             done              out - one-cycle pulse on completion
//             result, cout      out - sum/carry of last completed operation
//  Revision : 1.0 - initial release
// ============================================================================
module multiword_adder_seq
   import multiword_adder_seq_pkg::*;
#(
   parameter int SIZE  = 4,
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [SIZE*WORDS-1:0] op_a,
   input  logic [SIZE*WORDS-1:0] op_b,
   input  logic                  cin,
   output logic                  busy,
   output logic                  done,
   output logic [SIZE*WORDS-1:0] result,
   output logic                  cout
);

   localparam int              W        = SIZE * WORDS;
   localparam int              IDXW     = idx_width(WORDS);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

   state_t          state;
   logic [W-1:0]    a_reg;
   logic [W-1:0]    b_reg;
   logic [W-1:0]    work;
   logic [W-1:0]    work_next;
   logic            carry_reg;
   logic [IDXW-1:0] idx;

   logic [SIZE-1:0] slice_a;
   logic [SIZE-1:0] slice_b;
   logic [SIZE-1:0] slice_sum;
   logic            slice_cout;

   // Slice mux: present the current word of each operand to the adder.
   assign slice_a = a_reg[idx*SIZE +: SIZE];
   assign slice_b = b_reg[idx*SIZE +: SIZE];

   adder_generate_gates #(
      .SIZE (SIZE)
   ) u_adder (
      .A    (slice_a),
      .B    (slice_b),
      .cin  (carry_reg),
      .Sum  (slice_sum),
      .cout (slice_cout)
   );

   // Slice demux: the working sum with the current slice already merged in.
   // The last RUN edge copies this straight into result so the final slice
   // does not need an extra cycle.
   always_comb begin
      work_next                    = work;
      work_next[idx*SIZE +: SIZE]  = slice_sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         work      <= '0;
         carry_reg <= 1'b0;
         idx       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         cout      <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               work      <= work_next;
               carry_reg <= slice_cout;
               if (idx == LAST_IDX) begin
                  result <= work_next;
                  cout   <= slice_cout;
                  idx    <= '0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= ST_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end

            // IDLE and DONE accept a new operation identically; DONE just
            // additionally drops the done pulse on its way out.
            default: begin
               done <= 1'b0;
               if (start) begin
                  a_reg     <= op_a;
                  b_reg     <= op_b;
                  carry_reg <= cin;
                  idx       <= '0;
                  busy      <= 1'b1;
                  state     <= ST_RUN;
               end else begin
                  state     <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule : multiword_adder_seq
`default_nettype wire

// File: tb/tb_multiword_adder_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multiword_adder_seq
//  Purpose  : Self-checking bench. A transaction-level model (sum computed
//             with plain arithmetic, completion after a cycle countdown) is
//             compared against the SIZE=4/WORDS=4 instance every cycle;
//             directed vectors also check hand-computed literals. A second
//             WORDS=1 instance is swept over all 512 input combinations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multiword_adder_seq;

   localparam int SIZE  = 4;
   localparam int WORDS = 4;
   localparam int W     = SIZE * WORDS;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;

   logic         start1;
   logic [3:0]   op_a1;
   logic [3:0]   op_b1;
   logic         cin1;
   logic         busy1;
   logic         done1;
   logic [3:0]   result1;
   logic         cout1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   multiword_adder_seq #(.SIZE(SIZE), .WORDS(WORDS)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op_a   (op_a),
      .op_b   (op_b),
      .cin    (cin),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout)
   );

   multiword_adder_seq #(.SIZE(4), .WORDS(1)) dut1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start1),
      .op_a   (op_a1),
      .op_b   (op_b1),
      .cin    (cin1),
      .busy   (busy1),
      .done   (done1),
      .result (result1),
      .cout   (cout1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model of the WORDS=4 instance -------
   int           m_cnt;     // cycles left until completion, 0 = not running
   logic [W:0]   m_pend;
   logic         m_done;
   logic [W-1:0] m_result;
   logic         m_cout;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt    = 0;
         m_pend   = '0;
         m_done   = 1'b0;
         m_result = '0;
         m_cout   = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
               m_done = 1'b1;
               {m_cout, m_result} = m_pend;
            end
         end else if (start) begin
            m_pend = {1'b0, op_a} + {1'b0, op_b} + (W+1)'(cin);
            m_cnt  = WORDS;
         end
      end
   end

   always @(negedge clk) begin
      check("busy",   busy,   (m_cnt > 0));
      check("done",   done,   m_done);
      check("result", result, m_result);
      check("cout",   cout,   m_cout);
   end

   // ---------------- stimulus helpers -----------------------------------
   // Starting one negedge after start is raised, count negedges until done.
   // Done is expected WORDS+1 negedges later (WORDS RUN edges after accept).
   task automatic wait_done(input bit poke, output int cyc, output int busy_cnt);
      cyc      = 0;
      busy_cnt = 0;
      repeat (20) begin
         @(negedge clk);
         cyc++;
         if (busy) busy_cnt++;
         if (cyc == 1) start = 1'b0;
         if (poke && cyc == 2) begin
            op_a  = 16'hAAAA;
            op_b  = 16'h5555;
            cin   = 1'b1;
            start = 1'b1;
         end
         if (poke && cyc == 3) start = 1'b0;
         if (done) break;
      end
      start = 1'b0;
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input bit poke, input logic [W-1:0] exp_res, input logic exp_cout,
                         input string name);
      int cyc;
      int bcnt;
      @(negedge clk);
      op_a  = a;
      op_b  = b;
      cin   = c;
      start = 1'b1;
      wait_done(poke, cyc, bcnt);
      check({name, "_latency"}, cyc, WORDS + 1);
      check({name, "_busy_cycles"}, bcnt, WORDS);
      check({name, "_result"}, result, exp_res);
      check({name, "_cout"}, cout, exp_cout);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      int bcnt;
      logic [4:0] exp1;

      rst_n  = 1'b0;
      start  = 1'b0;
      op_a   = '0;
      op_b   = '0;
      cin    = 1'b0;
      start1 = 1'b0;
      op_a1  = '0;
      op_b1  = '0;
      cin1   = 1'b0;

      // Reset held for three cycles, then released with start low.
      repeat (3) @(negedge clk);
      check("rst_busy",   busy,   0);
      check("rst_done",   done,   0);
      check("rst_result", result, 16'h0000);
      check("rst_cout",   cout,   0);
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_busy",   busy,   0);
      check("idle_done",   done,   0);
      check("idle_result", result, 16'h0000);
      check("idle_cout",   cout,   0);

      run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, "basic");
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, "ripple");
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, "allones");

      // Start pulsed during RUN must be ignored; then back-to-back from DONE.
      run_op(16'h1234, 16'h4321, 1'b1, 1'b1, 16'h5556, 1'b0, "busy_start");
      op_a  = 16'h0F0F;
      op_b  = 16'h00F1;
      cin   = 1'b0;
      start = 1'b1;
      check("b2b_done_in_accept_cycle", done, 1);
      wait_done(1'b0, cyc, bcnt);
      check("b2b_gap",    cyc,    5);
      check("b2b_result", result, 16'h1000);
      check("b2b_cout",   cout,   0);

      // Reset in the middle of an operation.
      @(negedge clk);
      op_a  = 16'h1234;
      op_b  = 16'h4321;
      cin   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy",   busy,   0);
      check("midrst_done",   done,   0);
      check("midrst_result", result, 16'h0000);
      check("midrst_cout",   cout,   0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, "after_rst");

      // WORDS=1: exhaustive sweep, done exactly one edge after accept.
      for (int i = 0; i < 512; i++) begin
         @(negedge clk);
         op_a1  = i[3:0];
         op_b1  = i[7:4];
         cin1   = i[8];
         start1 = 1'b1;
         exp1   = {1'b0, op_a1} + {1'b0, op_b1} + {4'b0, cin1};
         @(negedge clk);
         start1 = 1'b0;
         check("w1_busy",       busy1, 1);
         check("w1_done_early", done1, 0);
         @(negedge clk);
         check("w1_done", done1, 1);
         check("w1_sum",  {cout1, result1}, exp1);
      end

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_multiword_adder_seq
`default_nettype wire
